// File: rtl/uart_loopback_buf_fsm.sv
// uart_loopback_buf_fsm: FIFO-buffered UART loopback with byte transform,
// line-buffered release, post-send gap and occupancy/overflow reporting.
module uart_loopback_buf_fsm #(
  parameter int         DEPTH      = 16,
  parameter int         AW         = 4,
  parameter logic [7:0] EOL_CHAR   = 8'h0D,
  parameter int         GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        tx_ready,
  input  logic        tx_done,
  input  logic [1:0]  mode,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic [1:0]  state_out,
  output logic [AW:0] fifo_count,
  output logic        overflow,
  output logic [7:0]  last_tx_byte
);

  localparam int GW =
    (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SEND      = 2'b01,
    WAIT_DONE = 2'b10,
    GAP       = 2'b11
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nx;
  logic [GW-1:0] gap_cnt;
  logic          rel;
  logic          rel_nx;
  logic          full;
  logic          push;
  logic          pop;
  logic          eligible;
  logic [7:0]    head;
  logic [7:0]    head_xf;

  function automatic logic [7:0] xform(
    input logic [7:0] b,
    input logic [1:0] m
  );
    logic [7:0] r;
    r = b;
    unique case (1'b1)
      (m == 2'd1): begin
        if (b >= 8'h61 && b <= 8'h7A)
          r = b - 8'h20;
      end
      (m == 2'd2): r = ~b;
      default: r = b;
    endcase
    return r;
  endfunction

  assign full     = (count == FULL);
  assign pop      = (state == SEND);
  // A full FIFO still takes a byte when the head leaves the same cycle
  assign push     = rx_dv && (!full || pop);
  assign eligible = (count != '0) &&
                    ((mode != 2'd3) || rel);
  assign head     = mem[rd_ptr];
  assign head_xf  = xform(head, mode);

  assign tx_dv      = (state == SEND);
  assign state_out  = state;
  assign fifo_count = count;

  always_comb begin
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + (AW+1)'(1);
      2'b01:   count_nx = count - (AW+1)'(1);
      default: count_nx = count;
    endcase
  end

  // Line release: opened by EOL or a full FIFO, closed once drained
  always_comb begin
    rel_nx = rel;
    if (count_nx == '0)
      rel_nx = 1'b0;
    else if ((push && rx_byte == EOL_CHAR) ||
             count_nx == FULL)
      rel_nx = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (eligible && tx_ready && gap_cnt == '0)
          state_nx = SEND;
      end
      SEND: state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done)
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt <= GW'(1))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rel          <= 1'b0;
      gap_cnt      <= '0;
      tx_byte      <= '0;
      overflow     <= 1'b0;
      last_tx_byte <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      rel   <= rel_nx;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (rx_dv && full && !pop)
        overflow <= 1'b1;
      // Transform is latched on entry so tx_byte is valid with tx_dv
      if (state == IDLE && state_nx == SEND)
        tx_byte <= head_xf;
      if (state == WAIT_DONE && tx_done) begin
        last_tx_byte <= tx_byte;
        gap_cnt      <= GAP_INIT;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rx_byte;
  end

endmodule

// File: tb/tb_uart_loopback_buf_fsm.sv
// Bench for uart_loopback_buf_fsm: queue scoreboard, transmitter responder,
// table vectors and directed multi-cycle sequences.
module tb_uart_loopback_buf_fsm;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_ready;
  logic        tx_done;
  logic [1:0]  mode;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [1:0]  state_out;
  logic [AW:0] fifo_count;
  logic        overflow;
  logic [7:0]  last_tx_byte;

  uart_loopback_buf_fsm #(
    .DEPTH(DEPTH),
    .AW(AW),
    .EOL_CHAR(8'h0D),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_dv(rx_dv),
    .rx_byte(rx_byte),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .mode(mode),
    .tx_dv(tx_dv),
    .tx_byte(tx_byte),
    .state_out(state_out),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .last_tx_byte(last_tx_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] q [$];
  logic [7:0] sent [$];
  logic [7:0] inq [$];
  bit         m_ovf;
  bit         resp_en;
  bit         hold;
  bit         started;
  bit         pend;
  int         busy;
  int         lat;
  int         nvec;
  int         nerr;
  logic [7:0] cur;
  logic [7:0] pend_b;
  logic [1:0] lm;

  function automatic logic [7:0] xf(
    input logic [7:0] b,
    input logic [1:0] m
  );
    if (m == 2'd1 && b >= "a" && b <= "z")
      return b - 8'd32;
    if (m == 2'd2)
      return ~b;
    return b;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One clock: score this cycle, advance model and responder
  task automatic tick();
    if (rst_n) begin
      chk("fifo_count", 32'(fifo_count), q.size());
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (tx_dv) begin
        chk("tx_dv_eligible", 32'(q.size() != 0), 1);
        if (q.size() != 0)
          chk("tx_byte", 32'(tx_byte), 32'(xf(q[0], lm)));
        sent.push_back(tx_byte);
      end
      if (resp_en && tx_dv) begin
        started = 1;
        cur = tx_byte;
      end
      if (resp_en && tx_done) begin
        pend = 1;
        pend_b = cur;
      end
      if (tx_dv && q.size() != 0)
        q.delete(0);
      if (rx_dv) begin
        if (q.size() < DEPTH)
          q.push_back(rx_byte);
        else
          m_ovf = 1;
      end
    end else begin
      q.delete();
      m_ovf = 0;
      pend = 0;
    end
    lm = mode;
    @(posedge clk);
    #1;
    rx_dv = 0;
    if (pend) begin
      chk("last_tx_byte", 32'(last_tx_byte), 32'(pend_b));
      pend = 0;
    end
    if (resp_en) begin
      tx_done = 0;
      if (started) begin
        started = 0;
        busy = lat;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0)
          tx_done = 1;
      end
      tx_ready = (busy == 0) && !started && !hold;
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_dv = 1;
    rx_byte = b;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 0;
    rx_dv = 0;
    started = 0;
    busy = 0;
    pend = 0;
    if (resp_en)
      tx_done = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (!(state_out == 2'b00 && fifo_count == 0) && k < bound) begin
      tick();
      k++;
    end
    chk("idle_reached", 32'(k < bound), 1);
  endtask

  task automatic wait_sent(input int n, input int bound);
    int k;
    k = 0;
    while (sent.size() < n && k < bound) begin
      tick();
      k++;
    end
    chk("sent_count", sent.size(), n);
  endtask

  initial begin
    int k;
    nvec = 0;
    nerr = 0;
    rst_n = 0;
    rx_dv = 0;
    rx_byte = 0;
    tx_ready = 0;
    tx_done = 0;
    mode = 0;
    resp_en = 1;
    hold = 0;
    lat = 3;
    lm = 0;
    m_ovf = 0;
    started = 0;
    pend = 0;
    busy = 0;

    tbl[0] = '{2'd1, 8'h61, 8'h41};
    tbl[1] = '{2'd1, 8'h7A, 8'h5A};
    tbl[2] = '{2'd1, 8'h5B, 8'h5B};
    tbl[3] = '{2'd1, 8'h31, 8'h31};
    tbl[4] = '{2'd1, 8'h60, 8'h60};
    tbl[5] = '{2'd1, 8'h7B, 8'h7B};
    tbl[6] = '{2'd2, 8'h0F, 8'hF0};
    tbl[7] = '{2'd2, 8'hA5, 8'h5A};
    tbl[8] = '{2'd0, 8'h41, 8'h41};
    tbl[9] = '{2'd3, 8'h0D, 8'h0D};

    do_reset();
    chk("rst_state", 32'(state_out), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_tx_dv", 32'(tx_dv), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_last", 32'(last_tx_byte), 0);

    // Latency and gap after a single echoed byte
    tick();
    push(8'h41);
    chk("lat_count1", 32'(fifo_count), 1);
    chk("lat_no_dv", 32'(tx_dv), 0);
    tick();
    chk("lat_dv", 32'(tx_dv), 1);
    chk("lat_byte", 32'(tx_byte), 8'h41);
    chk("lat_state_send", 32'(state_out), 1);
    k = 0;
    while (!tx_done && k < 20) begin
      tick();
      k++;
    end
    chk("lat_done_seen", 32'(tx_done), 1);
    tick();
    chk("gap1_state", 32'(state_out), 3);
    chk("gap1_last", 32'(last_tx_byte), 8'h41);
    tick();
    chk("gap2_state", 32'(state_out), 3);
    tick();
    chk("after_gap_state", 32'(state_out), 0);

    for (int i = 0; i < 10; i++) begin
      mode = tbl[i].m;
      tick();
      sent.delete();
      push(tbl[i].din);
      wait_sent(1, 50);
      if (sent.size() > 0)
        chk($sformatf("tbl%0d", i), 32'(sent[0]), 32'(tbl[i].dout));
      wait_idle(100);
    end

    // Overflow with the transmitter held off
    mode = 0;
    hold = 1;
    tx_ready = 0;
    tick();
    for (int i = 0; i < DEPTH + 2; i++)
      push(8'(i));
    chk("ovf_count", 32'(fifo_count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    sent.delete();
    hold = 0;
    wait_sent(16, 600);
    repeat (30) tick();
    chk("ovf_sent_total", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      chk("ovf_order", 32'(sent[i]), i);
    wait_idle(100);

    // Line-buffered mode
    do_reset();
    mode = 3;
    tick();
    sent.delete();
    push("h");
    push("i");
    repeat (50) tick();
    chk("m3_held", sent.size(), 0);
    push(8'h0D);
    wait_sent(3, 100);
    if (sent.size() >= 3) begin
      chk("m3_b0", 32'(sent[0]), "h");
      chk("m3_b1", 32'(sent[1]), "i");
      chk("m3_b2", 32'(sent[2]), 8'h0D);
    end
    wait_idle(100);
    push("x");
    repeat (20) tick();
    chk("m3_rel_cleared", sent.size(), 3);
    mode = 0;
    wait_sent(4, 50);
    if (sent.size() >= 4)
      chk("m3_switch_out", 32'(sent[3]), "x");
    wait_idle(100);
    mode = 3;
    tick();
    sent.delete();
    for (int i = 0; i < DEPTH; i++)
      push(8'h30 + 8'(i));
    wait_sent(16, 400);
    wait_idle(100);

    // Push coincident with pop while full
    do_reset();
    mode = 0;
    hold = 1;
    tx_ready = 0;
    tick();
    for (int i = 0; i < DEPTH; i++)
      push(8'h20 + 8'(i));
    chk("full_count", 32'(fifo_count), 16);
    chk("full_no_ovf", 32'(overflow), 0);
    hold = 0;
    k = 0;
    while (!tx_dv && k < 50) begin
      tick();
      k++;
    end
    chk("full_send_seen", 32'(tx_dv), 1);
    push(8'hAA);
    chk("coinc_count", 32'(fifo_count), 16);
    chk("coinc_no_ovf", 32'(overflow), 0);
    wait_idle(600);

    // Pointer wrap under continuous drain
    lat = 2;
    sent.delete();
    inq.delete();
    for (int i = 0; i < 40; i++) begin
      inq.push_back(8'(i * 7 + 3));
      push(8'(i * 7 + 3));
      repeat (5) tick();
    end
    wait_idle(500);
    chk("wrap_total", sent.size(), 40);
    for (int i = 0; i < 40 && i < sent.size(); i++)
      chk("wrap_order", 32'(sent[i]), 32'(inq[i]));

    // Randomised segments against the queue model
    for (int s = 0; s < 4; s++) begin
      mode = 2'($urandom_range(0, 2));
      lat = $urandom_range(1, 5);
      tick();
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 10)) tick();
        push(8'($urandom));
      end
      wait_idle(3000);
    end

    // Reset during WAIT_DONE with bytes queued
    do_reset();
    mode = 0;
    lat = 3;
    tick();
    push(8'h5C);
    wait_idle(100);
    chk("pre_rst_last", 32'(last_tx_byte), 8'h5C);
    hold = 1;
    tx_ready = 0;
    tick();
    for (int i = 0; i < 6; i++)
      push(8'h70 + 8'(i));
    hold = 0;
    k = 0;
    while (state_out != 2'b10 && k < 50) begin
      tick();
      k++;
    end
    chk("mid_wait_state", 32'(state_out), 2);
    resp_en = 0;
    started = 0;
    busy = 0;
    tx_done = 0;
    tx_ready = 0;
    chk("mid_queued", 32'(fifo_count), 5);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mid_rst_state", 32'(state_out), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_dv", 32'(tx_dv), 0);
    chk("mid_rst_last", 32'(last_tx_byte), 0);
    tx_done = 1;
    tick();
    tx_done = 0;
    chk("stray_done_state", 32'(state_out), 0);
    chk("stray_done_last", 32'(last_tx_byte), 0);
    tick();
    chk("stray_done_state2", 32'(state_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_loopback_buf_fsm.md
Name: uart_loopback_buf_fsm

Overview:
- Parametrised successor to the single-byte loopback FSM.
- Sits between the uart_rx_vlog outputs (rx_dv/rx_byte) and the uart_tx_vlog inputs (tx_dv/tx_byte, tx_ready/tx_done).
- Buffers received bytes in a DEPTH-entry FIFO and applies a selectable byte transform before transmitting.
- Supports line-buffered release and exports FIFO occupancy, a sticky overflow flag and the last completed TX byte for the 7-segment display path.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- AW, 4, log2(DEPTH); pointer width.
- EOL_CHAR, 8'h0D, line terminator for mode 3.
- GAP_CYCLES, 2, idle cycles enforced after each tx_done before the next send; 0 allowed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- rx_dv  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- tx_ready  in  1  transmitter idle, can accept tx_dv
- tx_done  in  1  one-cycle strobe, current byte fully shifted out
- mode  in  2  0 echo, 1 uppercase, 2 bitwise invert, 3 line-buffered echo
- tx_dv  out  1  one-cycle start strobe to transmitter
- tx_byte  out  8  byte to transmit
- state_out  out  2  FSM state encoding
- fifo_count  out  AW+1  current FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky; a byte was dropped
- last_tx_byte  out  8  byte whose transmission last completed

Behaviour:
- Reset: rst_n=0 sampled at a clk edge clears all of the following on that edge:
  - state=IDLE, rd/wr pointers=0, fifo_count=0.
  - tx_dv=0, tx_byte=0, overflow=0, last_tx_byte=0.
  - gap counter=0, release flag=0.
  - Reset mid-transmission discards FIFO contents and an in-flight tx_done is ignored. The transmitter itself is not reset by this block.
- FIFO push: on rx_dv=1 the byte is written at the edge.
  - If fifo_count==DEPTH and no pop occurs that cycle, the byte is dropped and overflow is set. overflow clears only on reset.
  - Push and pop in the same cycle when full: push accepted, count unchanged.
  - Pointers wrap modulo DEPTH.
- Release rule:
  - Modes 0–2: a byte is eligible whenever fifo_count>0.
  - Mode 3: eligible only while release=1.
    - release sets when an EOL_CHAR byte is pushed, or when fifo_count reaches DEPTH.
    - release clears when the FIFO becomes empty after a pop.
    - Switching out of mode 3 makes buffered bytes eligible immediately.
- FSM states and transitions (state_out encoding):
  - IDLE (00): go to SEND when eligible && tx_ready && gap counter==0.
  - SEND (01), exactly one cycle:
    - tx_dv=1.
    - tx_byte = transform(head), registered on entry so it is valid in the same cycle as tx_dv.
    - FIFO pops at the end of this cycle.
    - Go to WAIT_DONE.
  - WAIT_DONE (10): on tx_done, set last_tx_byte=tx_byte and load gap counter=GAP_CYCLES. Go to GAP, or to IDLE if GAP_CYCLES==0.
  - GAP (11): decrement the counter each cycle; go to IDLE when it reaches 0 (exactly GAP_CYCLES cycles in GAP).
- Transform is sampled at SEND; a mode change affects only subsequent sends.
  - Mode 1: bytes 0x61–0x7A have 0x20 subtracted; all other bytes pass unchanged.
  - Mode 2: tx_byte = ~head.
  - Modes 0 and 3: pass unchanged.
- Latency, idle system with empty FIFO and mode 0:
  - rx_dv in cycle N; fifo_count=1 in cycle N+1.
  - IDLE sees eligible in N+1; tx_dv=1 in cycle N+2.
- tx_byte holds its value between SENDs.
- tx_dv never asserts outside SEND.
- A tx_done outside WAIT_DONE is ignored.

Test Plan:
- Reset, then mode 0, rx_dv with 0x41 and tx_ready=1 → tx_dv=1 exactly 2 cycles later with tx_byte=0x41. After tx_done: last_tx_byte=0x41, then 2 GAP cycles, then state_out=00.
- Mode 1, bytes 0x61, 0x7A, 0x5B, 0x31 → transmitted 0x41, 0x5A, 0x5B, 0x31. Mode 2, byte 0x0F → 0xF0.
- Hold tx_ready=0 and push DEPTH+2 bytes (0x00..0x11) → fifo_count=16 and overflow=1. Release tx_ready → bytes 0x00..0x0F sent in order; 0x10 and 0x11 are absent.
- Mode 3, push 'h','i' → no tx_dv for 50 cycles. Push 0x0D → 'h','i',0x0D sent; release clears when the FIFO empties.
- Full FIFO, rx_dv coincident with SEND pop → byte accepted, count stays 16, overflow stays 0. Pointer wrap is verified by pushing 40 bytes with a continuous drain; the output sequence is identical to the input.
- rst_n=0 during WAIT_DONE with 5 bytes queued → next cycle: state_out=00, fifo_count=0, tx_dv=0, last_tx_byte=0. A subsequent tx_done pulse causes no state change.
